mold_seq_ctrl: RTL and testbench

MOLD_SEQ_CTRL -- requirements
Module: mold_seq_ctrl

---
 rtl/mold_seq_ctrl_pkg.sv | 25 ++
 rtl/mold_seq_ctrl_if.sv | 31 +++
 rtl/sat_counter.sv | 26 ++
 rtl/mold_seq_ctrl.sv | 128 ++++++++++++
 tb/tb_mold_seq_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/mold_seq_ctrl_pkg.sv
// Shared types and constants for the MoldUDP64 sequence controller.
// Holds the FSM state enum, Mold header record and request-count saturation helper.
package mold_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    UNSYNC = 2'd0,
    SYNCED = 2'd1,
    REQ    = 2'd2
  } moldState_t;

  localparam logic [15:0] MOLD_END_SESSION = 16'hFFFF;
  localparam logic [15:0] REQ_CNT_MAX      = 16'hFFFE;

  typedef struct packed {
    logic [79:0] sessId;
    logic [63:0] seqNum;
    logic [15:0] msgCnt;
  } moldHdr_t;

  // 16'hFFFF is reserved as the end-of-session marker, so requests top out one below it.
  function automatic logic [15:0] satReqCnt(input logic [63:0] gap);
    return (gap > 64'(REQ_CNT_MAX)) ? REQ_CNT_MAX : gap[15:0];
  endfunction

endpackage

// File: rtl/mold_seq_ctrl_if.sv
// Header-in / decision-out / retransmit-request bundle of the Mold sequence controller.
// slave is the controller's view, master is the parser/requester side.
interface mold_seq_ctrl_if #(parameter int CNT_W = 32);
  logic              hdrValidIn;
  logic [79:0]       sessIdIn;
  logic [63:0]       seqNumIn;
  logic [15:0]       msgCntIn;
  logic              resyncIn;
  logic              acceptOut;
  logic              dropOut;
  logic              packetLostOut;
  logic              reqValidOut;
  logic [63:0]       reqSeqOut;
  logic [15:0]       reqCntOut;
  logic              reqReadyIn;
  logic              reqOverrunOut;
  logic [CNT_W-1:0]  lostMsgCntOut;
  logic              syncedOut;

  modport slave (
    input  hdrValidIn, sessIdIn, seqNumIn, msgCntIn, resyncIn, reqReadyIn,
    output acceptOut, dropOut, packetLostOut, reqValidOut, reqSeqOut, reqCntOut,
           reqOverrunOut, lostMsgCntOut, syncedOut
  );

  modport master (
    output hdrValidIn, sessIdIn, seqNumIn, msgCntIn, resyncIn, reqReadyIn,
    input  acceptOut, dropOut, packetLostOut, reqValidOut, reqSeqOut, reqCntOut,
           reqOverrunOut, lostMsgCntOut, syncedOut
  );
endinterface

// File: rtl/sat_counter.sv
// Accumulator that adds a wide increment and clamps at its all-ones maximum.
module sat_counter #(
  parameter int W     = 32,
  parameter int INC_W = 64
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             addEn,
  input  logic [INC_W-1:0] inc,
  output logic [W-1:0]     cnt
);

  localparam int SUM_W = ((W > INC_W) ? W : INC_W) + 1;
  localparam logic [SUM_W-1:0] MAX = (SUM_W'(1) << W) - SUM_W'(1);

  logic [SUM_W-1:0] sum;

  // One extra bit of headroom means the sum itself can never wrap.
  assign sum = SUM_W'(cnt) + SUM_W'(inc);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN)      cnt <= '0;
    else if (addEn) cnt <= (sum > MAX) ? '1 : sum[W-1:0];
  end

endmodule

// File: rtl/mold_seq_ctrl.sv
// MoldUDP64 sequence tracker: accepts/drops frames by sequence number, detects gaps
// and raises a held retransmit request until the requester takes it.
module mold_seq_ctrl
  import mold_seq_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              clkIn,
  input  logic              rstNIn,
  mold_seq_ctrl_if.slave    bus
);

  moldState_t  state, stateNxt;
  logic [63:0] expSeq, expSeqNxt;
  logic [79:0] sessId, sessIdNxt;
  logic        acceptR, acceptNxt, dropR, dropNxt, lostR, lostNxt;
  logic        reqValidR, reqValidNxt, overrunR, overrunNxt;
  logic [63:0] reqSeqR, reqSeqNxt;
  logic [15:0] reqCntR, reqCntNxt;
  logic        addEn, handshake;
  logic [63:0] gap;
  moldHdr_t    hdr;

  assign hdr       = '{sessId: bus.sessIdIn, seqNum: bus.seqNumIn, msgCnt: bus.msgCntIn};
  assign gap       = hdr.seqNum - expSeq;
  assign handshake = reqValidR & bus.reqReadyIn;

  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      state     <= UNSYNC;
      expSeq    <= '0;
      sessId    <= '0;
      acceptR   <= 1'b0;
      dropR     <= 1'b0;
      lostR     <= 1'b0;
      reqValidR <= 1'b0;
      reqSeqR   <= '0;
      reqCntR   <= '0;
      overrunR  <= 1'b0;
    end else begin
      state     <= stateNxt;
      expSeq    <= expSeqNxt;
      sessId    <= sessIdNxt;
      acceptR   <= acceptNxt;
      dropR     <= dropNxt;
      lostR     <= lostNxt;
      reqValidR <= reqValidNxt;
      reqSeqR   <= reqSeqNxt;
      reqCntR   <= reqCntNxt;
      overrunR  <= overrunNxt;
    end
  end

  always_comb begin
    stateNxt    = state;
    expSeqNxt   = expSeq;
    sessIdNxt   = sessId;
    acceptNxt   = 1'b0;
    dropNxt     = 1'b0;
    lostNxt     = 1'b0;
    reqValidNxt = reqValidR;
    reqSeqNxt   = reqSeqR;
    reqCntNxt   = reqCntR;
    overrunNxt  = overrunR;
    addEn       = 1'b0;

    if (handshake) begin
      reqValidNxt = 1'b0;
      stateNxt    = SYNCED;
    end

    // Resync outranks any header in the same cycle; the header produces no decision.
    if (bus.resyncIn) begin
      stateNxt    = UNSYNC;
      reqValidNxt = 1'b0;
    end else if (bus.hdrValidIn) begin
      if (hdr.msgCnt == MOLD_END_SESSION) begin
        dropNxt     = 1'b1;
        stateNxt    = UNSYNC;
        reqValidNxt = 1'b0;
      end else if (state == UNSYNC) begin
        sessIdNxt = hdr.sessId;
        expSeqNxt = hdr.seqNum + 64'(hdr.msgCnt);
        acceptNxt = 1'b1;
        stateNxt  = SYNCED;
      end else if (hdr.sessId != sessId) begin
        dropNxt = 1'b1;
      end else if (hdr.seqNum == expSeq) begin
        acceptNxt = 1'b1;
        expSeqNxt = expSeq + 64'(hdr.msgCnt);
      end else if (hdr.seqNum < expSeq) begin
        dropNxt = 1'b1;
      end else begin
        acceptNxt = 1'b1;
        lostNxt   = 1'b1;
        addEn     = 1'b1;
        expSeqNxt = hdr.seqNum + 64'(hdr.msgCnt);
        // A request still waiting keeps its fields; the new gap is only counted and flagged.
        if (state == REQ && !handshake) begin
          overrunNxt = 1'b1;
        end else begin
          reqValidNxt = 1'b1;
          reqSeqNxt   = expSeq;
          reqCntNxt   = satReqCnt(gap);
          stateNxt    = REQ;
        end
      end
    end
  end

  sat_counter #(.W(CNT_W), .INC_W(64)) uLostCnt (
    .clk   (clkIn),
    .rstN  (rstNIn),
    .addEn (addEn),
    .inc   (gap),
    .cnt   (bus.lostMsgCntOut)
  );

  assign bus.acceptOut     = acceptR;
  assign bus.dropOut       = dropR;
  assign bus.packetLostOut = lostR;
  assign bus.reqValidOut   = reqValidR;
  assign bus.reqSeqOut     = reqSeqR;
  assign bus.reqCntOut     = reqCntR;
  assign bus.reqOverrunOut = overrunR;
  assign bus.syncedOut     = (state != UNSYNC);

endmodule

// File: tb/tb_mold_seq_ctrl.sv
// Scoreboard bench for mold_seq_ctrl: each header pushes its expected decision,
// a negedge monitor pops and compares when accept/drop pulses appear.
module tb_mold_seq_ctrl;
  import mold_seq_ctrl_pkg::*;

  localparam int CNT_W = 32;
  localparam logic [79:0] SESS_A = 80'hA5A5_0000_1111_2222_3333;
  localparam logic [79:0] SESS_B = 80'h5A5A_FFFF_4444_5555_6666;
  localparam logic [2:0]  ACC      = 3'b100;
  localparam logic [2:0]  DROP     = 3'b010;
  localparam logic [2:0]  ACC_LOST = 3'b101;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  always #2 clk = ~clk;

  mold_seq_ctrl_if #(.CNT_W(CNT_W)) bus ();
  mold_seq_ctrl #(.CNT_W(CNT_W)) dut (.clkIn(clk), .rstNIn(rstN), .bus(bus));

  typedef struct {
    logic [2:0] res;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int nChecks = 0;
  int nFail = 0;
  int cyc = 0;
  int pulseCnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.acceptOut || bus.dropOut) begin
      pulseCnt++;
      if (q.size() == 0) begin
        chk("spuriousDecision", {bus.acceptOut, bus.dropOut, bus.packetLostOut}, 3'b000);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("decision", {bus.acceptOut, bus.dropOut, bus.packetLostOut}, e.res);
        chk("latency", cyc, e.cyc);
      end
    end
  end

  task automatic waitDrain();
    for (int i = 0; i < 8 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      chk("decisionTimeout", q.size(), 0);
      q.delete();
    end
  endtask

  task automatic sendHdr(input logic [79:0] s, input logic [63:0] seq, input logic [15:0] cnt,
                         input logic [2:0] res, input logic rdy);
    exp_t e;
    bus.hdrValidIn = 1'b1;
    bus.sessIdIn   = s;
    bus.seqNumIn   = seq;
    bus.msgCntIn   = cnt;
    bus.reqReadyIn = rdy;
    e.res = res;
    e.cyc = cyc + 1;
    q.push_back(e);
    @(negedge clk);
    bus.hdrValidIn = 1'b0;
    bus.reqReadyIn = 1'b0;
    waitDrain();
  endtask

  task automatic checkReq(input logic vld, input logic [63:0] seq, input logic [15:0] cnt,
                          input logic ovr, input logic [CNT_W-1:0] lost);
    chk("reqValid", bus.reqValidOut, vld);
    chk("reqSeq", bus.reqSeqOut, seq);
    chk("reqCnt", bus.reqCntOut, cnt);
    chk("reqOverrun", bus.reqOverrunOut, ovr);
    chk("lostMsgCnt", bus.lostMsgCntOut, lost);
  endtask

  task automatic checkIdle();
    chk("idleAccept", bus.acceptOut, 0);
    chk("idleDrop", bus.dropOut, 0);
    chk("idlePacketLost", bus.packetLostOut, 0);
    chk("idleSynced", bus.syncedOut, 0);
    checkReq(1'b0, 64'd0, 16'd0, 1'b0, '0);
  endtask

  task automatic handshake();
    bus.reqReadyIn = 1'b1;
    @(negedge clk);
    bus.reqReadyIn = 1'b0;
    chk("reqValidAfterHs", bus.reqValidOut, 0);
    chk("syncedAfterHs", bus.syncedOut, 1);
  endtask

  task automatic doReset();
    rstN = 1'b0;
    repeat (3) @(negedge clk);
    checkIdle();
    rstN = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int pc;
    bus.hdrValidIn = 1'b0;
    bus.sessIdIn   = '0;
    bus.seqNumIn   = '0;
    bus.msgCntIn   = '0;
    bus.resyncIn   = 1'b0;
    bus.reqReadyIn = 1'b0;
    @(negedge clk);
    doReset();

    // First header synchronises, then a one-message gap.
    sendHdr(SESS_A, 64'd1, 16'd1, ACC, 1'b0);
    chk("syncedAfterFirst", bus.syncedOut, 1);
    checkReq(1'b0, 64'd0, 16'd0, 1'b0, 32'd0);
    sendHdr(SESS_A, 64'd3, 16'd1, ACC_LOST, 1'b0);
    checkReq(1'b1, 64'd2, 16'd1, 1'b0, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("holdValid", bus.reqValidOut, 1);
      chk("holdSeq", bus.reqSeqOut, 64'd2);
      chk("holdCnt", bus.reqCntOut, 16'd1);
    end
    handshake();

    // Duplicate, foreign session, heartbeat at expSeq=4.
    sendHdr(SESS_A, 64'd2, 16'd1, DROP, 1'b0);
    sendHdr(SESS_B, 64'd4, 16'd1, DROP, 1'b0);
    sendHdr(SESS_A, 64'd4, 16'd0, ACC, 1'b0);
    chk("syncedAfterHeartbeat", bus.syncedOut, 1);

    // Gap while a request is pending -> overrun.
    sendHdr(SESS_A, 64'd10, 16'd1, ACC_LOST, 1'b0);
    checkReq(1'b1, 64'd4, 16'd6, 1'b0, 32'd7);
    sendHdr(SESS_A, 64'd20, 16'd1, ACC_LOST, 1'b0);
    checkReq(1'b1, 64'd4, 16'd6, 1'b1, 32'd16);
    handshake();

    // Same-cycle handshake loads the new request without overrun.
    doReset();
    sendHdr(SESS_A, 64'd4, 16'd1, ACC, 1'b0);
    sendHdr(SESS_A, 64'd10, 16'd1, ACC_LOST, 1'b0);
    checkReq(1'b1, 64'd5, 16'd5, 1'b0, 32'd5);
    sendHdr(SESS_A, 64'd20, 16'd1, ACC_LOST, 1'b1);
    checkReq(1'b1, 64'd11, 16'd9, 1'b0, 32'd14);
    handshake();

    // Huge gap saturates reqCnt; lost counter driven to max-1 then max.
    sendHdr(SESS_A, 64'h10_0015, 16'd1, ACC_LOST, 1'b0);
    checkReq(1'b1, 64'd21, 16'hFFFE, 1'b0, 32'h0010_000E);
    handshake();
    sendHdr(SESS_A, 64'h1_0000_0006, 16'd1, ACC_LOST, 1'b0);
    checkReq(1'b1, 64'h10_0016, 16'hFFFE, 1'b0, 32'hFFFF_FFFE);
    handshake();
    sendHdr(SESS_A, 64'h1_0000_000C, 16'd1, ACC_LOST, 1'b0);
    checkReq(1'b1, 64'h1_0000_0007, 16'd5, 1'b0, 32'hFFFF_FFFF);

    // End of session while a request is pending.
    sendHdr(SESS_A, 64'h1_0000_000D, 16'hFFFF, DROP, 1'b0);
    chk("endSessReqValid", bus.reqValidOut, 0);
    chk("endSessSynced", bus.syncedOut, 0);
    sendHdr(SESS_A, 64'd100, 16'd1, ACC, 1'b0);
    sendHdr(SESS_A, 64'd103, 16'd1, ACC_LOST, 1'b0);
    checkReq(1'b1, 64'd101, 16'd2, 1'b0, 32'hFFFF_FFFF);
    handshake();

    // Resync coincident with a header.
    pc = pulseCnt;
    bus.hdrValidIn = 1'b1;
    bus.sessIdIn   = SESS_A;
    bus.seqNumIn   = 64'd104;
    bus.msgCntIn   = 16'd1;
    bus.resyncIn   = 1'b1;
    @(negedge clk);
    bus.hdrValidIn = 1'b0;
    bus.resyncIn   = 1'b0;
    repeat (3) @(negedge clk);
    chk("resyncNoPulse", pulseCnt - pc, 0);
    chk("resyncSynced", bus.syncedOut, 0);
    sendHdr(SESS_A, 64'd50, 16'd1, ACC, 1'b0);
    chk("resyncRelatch", bus.syncedOut, 1);

    // Asynchronous reset mid-cycle while a request is pending.
    sendHdr(SESS_A, 64'd60, 16'd1, ACC_LOST, 1'b0);
    checkReq(1'b1, 64'd51, 16'd9, 1'b0, 32'hFFFF_FFFF);
    @(posedge clk);
    #1 rstN = 1'b0;
    #0.5;
    checkIdle();
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    sendHdr(SESS_A, 64'd7, 16'd1, ACC, 1'b0);
    checkReq(1'b0, 64'd0, 16'd0, 1'b0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
